feature_loader_9: RTL and testbench
===================================

FEATURE_LOADER_9 -- requirements
Module: feature_loader_9

Interface
REQ-001 Parameter: WIDTH, default 16, data word width in bits (signed fixed-point, treated as opaque bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clear  input  1  synchronous abort/flush of the current vector.
REQ-005 in_data  input  WIDTH  serial input word.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 select  output  4  index (0..8) of the next slot to be written; steers a downstream 9-way demux.
REQ-009 output_1 .. output_9  output  WIDTH each  registered vector slots 1..9.
REQ-010 vec_valid  output  1  all nine slots hold a complete vector.
REQ-011 vec_ready  input  1  consumer takes the vector this cycle.

Function
REQ-012 Two states: LOAD (collecting words) and FULL (presenting vector); state and index are registered.
REQ-013 in_ready SHALL be 1 in LOAD and 0 in FULL, decoded from state only (no combinational path from vec_ready or in_valid).
REQ-014 vec_valid SHALL be 1 in FULL and 0 in LOAD.
REQ-015 Accept = in_valid & in_ready; on accept, slot (select+1) SHALL load in_data at that edge; other slots hold.
REQ-016 On accept with select < 8: select increments by 1, state stays LOAD.
REQ-017 On accept with select == 8: select wraps to 0, state goes to FULL; vec_valid is 1 from the next cycle.
REQ-018 in_valid without accept (FULL state) SHALL be ignored; upstream holds the word until in_ready.
REQ-019 In FULL, vec_ready=1 SHALL return state to LOAD at that edge; output_1..output_9 SHALL hold their values (not cleared).
REQ-020 In FULL with vec_ready=0, all outputs SHALL hold indefinitely.
REQ-021 vec_ready in LOAD SHALL be ignored.
REQ-022 Minimum period per vector: 10 cycles (9 accepts + 1 FULL cycle); no same-cycle bypass from FULL to accept.
REQ-023 select SHALL never exceed 8; values 9..15 are unreachable.
REQ-024 clear=1 SHALL, at the edge: state to LOAD, select to 0, output_1..output_9 to 0; clear has priority over accept and vec_ready in the same cycle.
REQ-025 in_valid gaps (0 for any number of cycles) mid-vector SHALL not change select or slot contents.

Reset
REQ-026 rst_n=0 SHALL immediately (without clock) force state LOAD, select 0, output_1..output_9 0, vec_valid 0, in_ready 1.
REQ-027 Reset asserted mid-vector SHALL discard the partial vector; after release, the first accepted word goes to output_1.
REQ-028 Reset release is synchronised by the system; block makes no state change on the release edge other than normal operation.

Verification
REQ-029 Reset, then stream 0x0001..0x0009 with in_valid=1 continuously, vec_ready=0 -> after 9 accepts output_1..9 = 0x0001..0x0009, vec_valid=1, in_ready=0, select=0.
REQ-030 From REQ-029 state, hold vec_ready=0 for 20 cycles with in_valid=1, in_data=0xFFFF -> outputs unchanged, no accept; then vec_ready=1 one cycle -> next cycle in_ready=1, vec_valid=0, outputs still 0x0001..0x0009.
REQ-031 Send 4 words 0x00A0..0x00A3 with random in_valid gaps -> select=4, output_1..4 = 0x00A0..0x00A3, output_5..9 = 0, vec_valid=0.
REQ-032 After 5 accepted words assert clear together with in_valid=1 -> select=0, all outputs 0, that word not stored; next 9 words fill output_1..9 correctly.
REQ-033 Assert rst_n=0 asynchronously between clock edges after 7 accepted words -> outputs and select 0 before next edge; after release a full 9-word vector completes normally.
REQ-034 Back-to-back vectors with vec_ready tied 1 -> one vector every 10 cycles, vec_valid high exactly one cycle per vector, select sequence 0..8 repeating.

Source files
------------

// File: rtl/feature_loader_9.sv
// feature_loader_9: serial-to-parallel loader that collects nine WIDTH-bit
// words into registered slots output_1..output_9, then presents them as one
// vector with a valid/ready handshake. Two-state FSM (LOAD / FULL) plus a
// 0..8 slot index exported as select for a downstream 9-way demux.
module feature_loader_9 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       select,
    output logic [WIDTH-1:0] output_1,
    output logic [WIDTH-1:0] output_2,
    output logic [WIDTH-1:0] output_3,
    output logic [WIDTH-1:0] output_4,
    output logic [WIDTH-1:0] output_5,
    output logic [WIDTH-1:0] output_6,
    output logic [WIDTH-1:0] output_7,
    output logic [WIDTH-1:0] output_8,
    output logic [WIDTH-1:0] output_9,
    output logic             vec_valid,
    input  logic             vec_ready
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam logic [3:0] LAST_IDX = 4'd8;
    localparam int         NSLOTS   = 9;

    state_e           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [WIDTH-1:0] slot_q [NSLOTS];
    logic [WIDTH-1:0] slot_d [NSLOTS];
    logic             accept_s;

    // Handshake flags come from the state register alone, so neither
    // in_valid nor vec_ready has a combinational path to an output.
    assign in_ready  = (state_q == ST_LOAD);
    assign vec_valid = (state_q == ST_FULL);
    assign accept_s  = in_valid && (state_q == ST_LOAD);
    assign select    = sel_q;

    assign output_1 = slot_q[0];
    assign output_2 = slot_q[1];
    assign output_3 = slot_q[2];
    assign output_4 = slot_q[3];
    assign output_5 = slot_q[4];
    assign output_6 = slot_q[5];
    assign output_7 = slot_q[6];
    assign output_8 = slot_q[7];
    assign output_9 = slot_q[8];

    // Next-state, next-index and slot-write decode; clear overrides everything.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        for (int i = 0; i < NSLOTS; i++) begin
            slot_d[i] = slot_q[i];
        end

        if (clear) begin
            state_d = ST_LOAD;
            sel_d   = 4'd0;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (accept_s) begin
                        for (int i = 0; i < NSLOTS; i++) begin
                            if (sel_q == 4'(i)) begin
                                slot_d[i] = in_data;
                            end else begin
                                slot_d[i] = slot_q[i];
                            end
                        end
                        if (sel_q >= LAST_IDX) begin
                            // Ninth word: wrap the index and present the vector.
                            sel_d   = 4'd0;
                            state_d = ST_FULL;
                        end else begin
                            sel_d   = sel_q + 4'd1;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        sel_d   = sel_q;
                        state_d = ST_LOAD;
                    end
                end
                ST_FULL: begin
                    // Slots keep their contents after hand-off; only state moves.
                    if (vec_ready) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    sel_d   = 4'd0;
                end
            endcase
        end
    end

    // State, index and slot registers with asynchronous reset to an empty LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
            sel_q   <= 4'd0;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            for (int i = 0; i < NSLOTS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_feature_loader_9.sv
// tb_feature_loader_9: randomized + directed bench for feature_loader_9.
// A word-count reference model predicts state each cycle; completed vectors
// go into a scoreboard queue that the monitor pops when vec_valid rises.
module tb_feature_loader_9;

    localparam int W  = 16;
    localparam int VW = 9 * W;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          clear     = 1'b0;
    logic [W-1:0]  in_data   = '0;
    logic          in_valid  = 1'b0;
    logic          vec_ready = 1'b0;
    logic          in_ready;
    logic          vec_valid;
    logic [3:0]    select;
    logic [W-1:0]  output_1, output_2, output_3, output_4, output_5;
    logic [W-1:0]  output_6, output_7, output_8, output_9;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: words collected so far, a "vector waiting" flag and the slot image.
    int            m_cnt  = 0;
    bit            m_full = 1'b0;
    logic [W-1:0]  m_slots [9];
    logic [VW-1:0] exp_q [$];
    int            vv_cnt = 0;

    feature_loader_9 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .select(select),
        .output_1(output_1), .output_2(output_2), .output_3(output_3),
        .output_4(output_4), .output_5(output_5), .output_6(output_6),
        .output_7(output_7), .output_8(output_8), .output_9(output_9),
        .vec_valid(vec_valid), .vec_ready(vec_ready)
    );

    // Free-running clock.
    initial forever #5 clk = ~clk;

    function automatic logic [VW-1:0] dut_vec();
        return {output_9, output_8, output_7, output_6, output_5,
                output_4, output_3, output_2, output_1};
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) v[i*W +: W] = m_slots[i];
        return v;
    endfunction

    // Vector with slot i = base + i for the first n slots, zero elsewhere.
    function automatic logic [VW-1:0] seq_vec(input logic [W-1:0] base, input int n);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*W +: W] = base + W'(i);
        return v;
    endfunction

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: updates from driven inputs only, following the loader rules.
    initial begin
        for (int i = 0; i < 9; i++) m_slots[i] = '0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n || clear) begin
                m_cnt  = 0;
                m_full = 1'b0;
                for (int i = 0; i < 9; i++) m_slots[i] = '0;
            end else if (!m_full) begin
                if (in_valid) begin
                    m_slots[m_cnt] = in_data;
                    m_cnt++;
                    if (m_cnt == 9) begin
                        m_cnt  = 0;
                        m_full = 1'b1;
                        exp_q.push_back(model_vec());
                    end
                end
            end else if (vec_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: per-cycle control/slot check plus scoreboard pop on each new vector.
    initial begin
        bit vv_prev;
        logic [VW-1:0] e;
        vv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("in_ready", VW'(in_ready), VW'(!m_full));
                check("vec_valid", VW'(vec_valid), VW'(m_full));
                check("select", VW'(select), VW'(m_cnt));
                check("slots", dut_vec(), model_vec());
                if (vec_valid) vv_cnt++;
                if (vec_valid && !vv_prev) begin
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_vector", VW'(1), VW'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_vector", dut_vec(), e);
                    end
                end
                vv_prev = vec_valid;
            end else begin
                vv_prev = 1'b0;
            end
        end
    end

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit r, input bit c);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        vec_ready = r;
        clear     = c;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [W-1:0] d, input int max_gap);
        repeat ($urandom_range(0, max_gap)) idle();
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    // Stimulus: directed scenarios followed by a randomized soak.
    initial begin
        int vv_before;
        #1 rst_n = 1'b0;
        #1;
        check("reset_in_ready", VW'(in_ready), VW'(1));
        check("reset_vec_valid", VW'(vec_valid), VW'(0));
        check("reset_select", VW'(select), VW'(0));
        check("reset_slots", dut_vec(), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous stream 1..9 with no consumer.
        for (int i = 1; i <= 9; i++) cyc(1'b1, W'(i), 1'b0, 1'b0);
        idle();
        check("full_slots", dut_vec(), seq_vec(16'h0001, 9));
        check("full_vec_valid", VW'(vec_valid), VW'(1));
        check("full_in_ready", VW'(in_ready), VW'(0));
        check("full_select", VW'(select), VW'(0));

        // Stalled consumer with a pending upstream word, then one handshake.
        repeat (20) cyc(1'b1, 16'hFFFF, 1'b0, 1'b0);
        cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
        check("stall_slots", dut_vec(), seq_vec(16'h0001, 9));
        check("stall_vec_valid", VW'(vec_valid), VW'(1));
        idle();
        check("release_in_ready", VW'(in_ready), VW'(1));
        check("release_vec_valid", VW'(vec_valid), VW'(0));
        check("release_slots", dut_vec(), seq_vec(16'h0001, 9));

        // Partial vector with random gaps.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) send(16'h00A0 + W'(i), 3);
        idle();
        check("partial_select", VW'(select), VW'(4));
        check("partial_slots", dut_vec(), seq_vec(16'h00A0, 4));
        check("partial_vec_valid", VW'(vec_valid), VW'(0));

        // Fifth word, then clear together with a valid word.
        send(16'h00A4, 2);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b1);
        idle();
        check("clear_select", VW'(select), VW'(0));
        check("clear_slots", dut_vec(), '0);
        for (int i = 0; i < 9; i++) send(16'h0C00 + W'(i), 2);
        idle();
        check("after_clear_slots", dut_vec(), seq_vec(16'h0C00, 9));
        check("after_clear_vec_valid", VW'(vec_valid), VW'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Asynchronous reset between edges after 7 accepted words.
        for (int i = 0; i < 7; i++) send(16'h0D00 + W'(i), 1);
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("async_rst_select", VW'(select), VW'(0));
        check("async_rst_slots", dut_vec(), '0);
        check("async_rst_in_ready", VW'(in_ready), VW'(1));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) send(16'h0E00 + W'(i), 1);
        idle();
        check("post_rst_slots", dut_vec(), seq_vec(16'h0E00, 9));
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle();

        // Back-to-back vectors with the consumer always ready.
        vv_before = vv_cnt;
        repeat (30) cyc(1'b1, W'($urandom), 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("b2b_full_cycles", VW'(vv_cnt - vv_before), VW'(3));

        // Randomized soak: gaps, random data, random consumer, rare clears.
        repeat (400) begin
            cyc($urandom_range(0, 3) != 0, W'($urandom), 1'($urandom_range(0, 1)),
                $urandom_range(0, 31) == 0);
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        repeat (3) idle();
        @(negedge clk);
        #1;
        check("sb_drained", VW'(exp_q.size()), VW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
